// File: rtl/frodo_seq_pkg.sv
// Shared types and constants for the Frodo instruction sequencer.
package frodo_seq_pkg;

    localparam int unsigned DEF_INST_WIDTH = 28;
    localparam int unsigned DEF_PC_WIDTH   = 10;
    localparam int unsigned OPCODE_WIDTH   = 3;
    localparam int unsigned BASE_PC_DEPTH  = 16;

    localparam logic [OPCODE_WIDTH-1:0] END_OPCODE = 3'b111;

    localparam logic [1:0] MODE_KEYGEN  = 2'b00;
    localparam logic [1:0] MODE_ENCAPS  = 2'b01;
    localparam logic [1:0] MODE_DECAPS  = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    // Program base per {level, mode_ctrl}; the mode==11 slots are never selected.
    localparam logic [DEF_PC_WIDTH-1:0] BASE_PC [BASE_PC_DEPTH] = '{
        10'h000, 10'h040, 10'h3FE, 10'h000,
        10'h080, 10'h0C0, 10'h100, 10'h000,
        10'h140, 10'h1C0, 10'h200, 10'h000,
        10'h240, 10'h280, 10'h180, 10'h000
    };

endpackage

// File: rtl/inst_sequencer.sv
// Instruction sequencer: walks the external program ROM from a per-mode base
// address and issues each instruction over a valid/ready handshake.
// Optional performance counters: define INST_SEQ_PERF_CNT_EN.
module inst_sequencer
    import frodo_seq_pkg::*;
#(
    parameter int unsigned INST_WIDTH = DEF_INST_WIDTH,
    parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            level,
    input  logic [1:0]            mode_ctrl,
    input  logic                  start,
    output logic [PC_WIDTH-1:0]   rom_addr,
    input  logic [INST_WIDTH-1:0] rom_data,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [PC_WIDTH-1:0]   pc
`ifdef INST_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           cyc_cnt,
    output logic [15:0]           inst_cnt
`endif
);

    seq_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [PC_WIDTH-1:0]   base_pc;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                  start_acc;

    assign base_pc   = PC_WIDTH'(BASE_PC[{level, mode_ctrl}]);
    assign opcode    = rom_data[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign start_acc = (state_q == ST_IDLE) && start;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            rom_addr_q   <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rom_addr_q   <= rom_addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic; rom_addr is loaded on entry to FETCH so ROM data is ready in LATCH.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rom_addr_d   = rom_addr_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_ctrl != MODE_ILLEGAL) begin
                        pc_d       = base_pc;
                        rom_addr_d = base_pc;
                        err_d      = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (opcode == END_OPCODE) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    inst_d       = rom_data;
                    inst_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    if (pc_q == '1) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        pc_d       = pc_q + PC_WIDTH'(1);
                        rom_addr_d = pc_q + PC_WIDTH'(1);
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_addr   = rom_addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pc         = pc_q;

`ifdef INST_SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [15:0] inst_cnt_q, inst_cnt_d;

    // Saturating busy-cycle and issued-instruction counters, cleared on start.
    always_comb begin
        cyc_cnt_d  = cyc_cnt_q;
        inst_cnt_d = inst_cnt_q;
        if (start_acc) begin
            cyc_cnt_d  = '0;
            inst_cnt_d = '0;
        end else begin
            if (busy_q && (cyc_cnt_q != '1)) begin
                cyc_cnt_d = cyc_cnt_q + 32'(1);
            end
            if (inst_valid_q && inst_ready && (inst_cnt_q != '1)) begin
                inst_cnt_d = inst_cnt_q + 16'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign cyc_cnt  = cyc_cnt_q;
    assign inst_cnt = inst_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: program ROM model, transaction-level
// reference walk of the program, directed scenarios plus randomized programs.
module tb_inst_sequencer;

    localparam int unsigned IW = 28;
    localparam int unsigned PW = 10;
    localparam int unsigned ROM_DEPTH = 1024;
    localparam logic [IW-1:0] END_WORD = 28'hE000000;

    logic          clk;
    logic          rst;
    logic [1:0]    level;
    logic [1:0]    mode_ctrl;
    logic          start;
    logic [PW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] pc;
`ifdef INST_SEQ_PERF_CNT_EN
    logic [31:0]   cyc_cnt;
    logic [15:0]   inst_cnt;
`endif

    inst_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .level      (level),
        .mode_ctrl  (mode_ctrl),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc)
`ifdef INST_SEQ_PERF_CNT_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .inst_cnt   (inst_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program ROM.
    logic [IW-1:0] mem [ROM_DEPTH];
    always @(posedge clk) rom_data <= mem[rom_addr];

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Program base addresses per {level, mode}.
    function automatic int base_of(input logic [1:0] lv, input logic [1:0] md);
        case ({lv, md})
            4'b0000: return 'h000;  4'b0001: return 'h040;  4'b0010: return 'h3FE;
            4'b0100: return 'h080;  4'b0101: return 'h0C0;  4'b0110: return 'h100;
            4'b1000: return 'h140;  4'b1001: return 'h1C0;  4'b1010: return 'h200;
            4'b1100: return 'h240;  4'b1101: return 'h280;  4'b1110: return 'h180;
            default: return 0;
        endcase
    endfunction

    function automatic logic [IW-1:0] rand_word();
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        return {op, 25'($urandom)};
    endfunction

    // Place n non-END words at base followed by END (when it fits in the ROM).
    task automatic load_prog(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < int'(ROM_DEPTH)) mem[base + i] = rand_word();
        end
        if (base + n < int'(ROM_DEPTH)) mem[base + n] = END_WORD;
    endtask

    // One start request; ready_mode 0=always, 1=random, 2=5-cycle stall on 2nd inst.
    task automatic run_prog(input logic [1:0] lv, input logic [1:0] md,
                            input int ready_mode, input bit extra_start);
        logic [IW-1:0] exp_q[$];
        logic [IW-1:0] prev_inst;
        bit   illegal, exp_err, seen_valid, prev_valid, prev_hs, rdy, hs;
        int   base, a, n_exp, done_k, done_cnt, issued, stalls, stall_run;
        int   busy_cycles, valid_cycles, exp_done_k, exp_pc;

        illegal = (md == 2'b11);
        exp_err = illegal;
        base = 0;
        n_exp = 0;
        if (!illegal) begin
            base = base_of(lv, md);
            a = base;
            forever begin
                if (mem[a][IW-1 -: 3] == 3'b111) break;
                exp_q.push_back(mem[a]);
                if (a == int'(ROM_DEPTH) - 1) begin
                    exp_err = 1'b1;
                    break;
                end
                a++;
            end
            n_exp = exp_q.size();
        end

        done_k = 0; done_cnt = 0; issued = 0; stalls = 0; stall_run = 0;
        busy_cycles = 0; valid_cycles = 0;
        seen_valid = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; prev_inst = '0;

        level = lv;
        mode_ctrl = md;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1 && !illegal) check_eq("err_cleared_on_start", 64'(err), 64'd0);
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_k = k;
                    check_eq("err_at_done", 64'(err), 64'(exp_err));
                    if (!illegal) begin
                        exp_pc = exp_err ? base + n_exp - 1 : base + n_exp;
                        check_eq("pc_at_done", 64'(pc), 64'(exp_pc));
                    end
                end
            end
            if (inst_valid) begin
                valid_cycles++;
                if (!seen_valid) begin
                    check_eq("first_valid_latency", 64'(k), 64'd3);
                    if (extra_start) begin
                        start = 1'b1;
                        level = ~lv;
                        mode_ctrl = 2'b00;
                    end
                end
                seen_valid = 1'b1;
                if (prev_valid && !prev_hs) begin
                    check_eq("inst_stable_stall", 64'(inst), 64'(prev_inst));
                    check_eq("rom_addr_hold", 64'(rom_addr), 64'(base + issued));
                end
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = !(issued == 1 && stall_run < 5);
            endcase
            if (inst_valid && !rdy) begin
                stalls++;
                if (issued == 1) stall_run++;
            end
            inst_ready = rdy;
            hs = inst_valid && rdy;
            if (hs) begin
                if (exp_q.size() > 0) check_eq("inst_order", 64'(inst), 64'(exp_q.pop_front()));
                else check_eq("unexpected_inst", 64'd1, 64'd0);
                issued++;
            end
            prev_valid = inst_valid;
            prev_hs = hs;
            prev_inst = inst;
            if (done_cnt > 0 && k == done_k + 1) begin
                check_eq("busy_after_done", 64'(busy), 64'd0);
                break;
            end
        end

        check_eq("done_count", 64'(done_cnt), 64'd1);
        check_eq("issued_count", 64'(issued), 64'(n_exp));
        if (illegal) begin
            check_eq("illegal_done_k", 64'(done_k), 64'd1);
            check_eq("illegal_busy", 64'(busy_cycles), 64'd0);
            check_eq("illegal_valid", 64'(valid_cycles), 64'd0);
        end else begin
            exp_done_k = exp_err ? 3 * n_exp + 1 + stalls : 3 * (n_exp + 1) + stalls;
            check_eq("done_latency", 64'(done_k), 64'(exp_done_k));
            check_eq("busy_cycles", 64'(busy_cycles), 64'(exp_done_k));
`ifdef INST_SEQ_PERF_CNT_EN
            check_eq("perf_inst_cnt", 64'(inst_cnt), 64'(n_exp));
            check_eq("perf_cyc_cnt", 64'(cyc_cnt), 64'(exp_done_k));
`endif
        end
        inst_ready = 1'b0;
    endtask

    // Start a program, then reset while an instruction is pending.
    task automatic reset_mid(input logic [1:0] lv, input logic [1:0] md);
        bit got_valid;
        int stray;
        got_valid = 1'b0;
        stray = 0;
        level = lv;
        mode_ctrl = md;
        start = 1'b1;
        inst_ready = 1'b0;
        for (int k = 0; k < 20 && !got_valid; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inst_valid) got_valid = 1'b1;
        end
        check_eq("reset_mid_reached_issue", 64'(got_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_pc", 64'(pc), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (inst_valid || done || busy) stray++;
        end
        check_eq("rst_quiet_after", 64'(stray), 64'd0);
        inst_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start = 1'b0;
        level = 2'b00;
        mode_ctrl = 2'b00;
        inst_ready = 1'b0;
        for (int i = 0; i < int'(ROM_DEPTH); i++) mem[i] = END_WORD;

        repeat (3) @(negedge clk);
        check_eq("reset_pc", 64'(pc), 64'd0);
        check_eq("reset_rom_addr", 64'(rom_addr), 64'd0);
        check_eq("reset_inst", 64'(inst), 64'd0);
        check_eq("reset_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        load_prog('h180, 3);
        run_prog(2'b11, 2'b10, 0, 1'b0);
        run_prog(2'b11, 2'b10, 2, 1'b0);
        run_prog(2'b01, 2'b11, 0, 1'b0);
        run_prog(2'b11, 2'b10, 0, 1'b0);
        run_prog(2'b11, 2'b10, 0, 1'b1);

        mem['h3FE] = rand_word();
        mem['h3FF] = rand_word();
        run_prog(2'b00, 2'b10, 0, 1'b0);

        reset_mid(2'b11, 2'b10);
        run_prog(2'b11, 2'b10, 1, 1'b0);

        load_prog('h080, 0);
        run_prog(2'b01, 2'b00, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [1:0] lv, md;
            lv = 2'($urandom_range(0, 3));
            md = 2'($urandom_range(0, 3));
            if (md != 2'b11) load_prog(base_of(lv, md), int'($urandom_range(0, 4)));
            run_prog(lv, md, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
